rst_seq_ctrl: RTL

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for a tx clock-mux speed change.
// Holds the tx datapath and RTC domain in reset after system reset.
// On each accepted mode request it sequences the tx reset around the
// clock-mux select change. All outputs are registered from one FSM process.
module rst_seq_ctrl #(
    parameter int INIT_CYCLES = 32,
    parameter int PRE_CYCLES  = 4,
    parameter int MUX_CYCLES  = 8,
    parameter int POST_CYCLES = 16
) (
    input  logic pbus_clk,
    input  logic rst_sys_n,
    input  logic mode_req_valid_i,
    input  logic mode_req_i,
    input  logic sw_rst_i,
    output logic mode_req_ready_o,
    output logic mii_mode_o,
    output logic tx_rst_n_o,
    output logic rtc_rst_n_o,
    output logic seq_busy_o,
    output logic seq_done_o
);

    // Counter reload value: N-1, with a length of 0 treated as 1 cycle.
    function automatic logic [15:0] load_val(input int n);
        logic [15:0] v_s;
        if (n <= 1) begin
            v_s = 16'd0;
        end else begin
            v_s = 16'(n - 1);
        end
        return v_s;
    endfunction

    localparam logic [15:0] INIT_LD = load_val(INIT_CYCLES);
    localparam logic [15:0] PRE_LD  = load_val(PRE_CYCLES);
    localparam logic [15:0] MUX_LD  = load_val(MUX_CYCLES);
    localparam logic [15:0] POST_LD = load_val(POST_CYCLES);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_IDLE    = 3'd5
    } state_t;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        mode_lat_r;
    logic        ready_r;
    logic        mii_r;
    logic        tx_rst_n_r;
    logic        rtc_rst_n_r;
    logic        busy_r;
    logic        done_r;

    // Sequencer FSM: state, down-counter, latched request and all outputs.
    always_ff @(posedge pbus_clk) begin
        if (!rst_sys_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= INIT_LD;
            mode_lat_r  <= 1'b0;
            ready_r     <= 1'b0;
            mii_r       <= 1'b0;
            tx_rst_n_r  <= 1'b0;
            rtc_rst_n_r <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else if (sw_rst_i) begin
            // Full restart; the mux select keeps its last value.
            state_r     <= ST_INIT;
            cnt_r       <= INIT_LD;
            ready_r     <= 1'b0;
            tx_rst_n_r  <= 1'b0;
            rtc_rst_n_r <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == 16'd0) begin
                        state_r     <= ST_RELEASE;
                        cnt_r       <= POST_LD;
                        rtc_rst_n_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_SWITCH;
                        cnt_r   <= MUX_LD;
                        mii_r   <= mode_lat_r;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_SWITCH: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_RELEASE;
                        cnt_r   <= POST_LD;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == 16'd0) begin
                        state_r    <= ST_DONE;
                        tx_rst_n_r <= 1'b1;
                        done_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                ST_IDLE: begin
                    if (mode_req_valid_i && ready_r) begin
                        mode_lat_r <= mode_req_i;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (mode_req_i == mii_r) begin
                            // Already in the requested mode: no reset pulse.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_ASSERT;
                            cnt_r      <= PRE_LD;
                            tx_rst_n_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover through a full restart.
                    state_r     <= ST_INIT;
                    cnt_r       <= INIT_LD;
                    ready_r     <= 1'b0;
                    tx_rst_n_r  <= 1'b0;
                    rtc_rst_n_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign mode_req_ready_o = ready_r;
    assign mii_mode_o       = mii_r;
    assign tx_rst_n_o       = tx_rst_n_r;
    assign rtc_rst_n_o      = rtc_rst_n_r;
    assign seq_busy_o       = busy_r;
    assign seq_done_o       = done_r;

endmodule
